aes_round_sequencer: RTL and testbench

Iterative AES-128 encryption controller that time-multiplexes one combinational round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey plus one key-expansion step) over the 10 cipher rounds. It owns the 128-bit state and round-key registers, performs the initial AddRoundKey, and drives round number, Rcon and final-round select to the datapath. It sits between the block-level valid/ready interface and the round logic; one block is in flight at a time.

---
 rtl/aes_round_sequencer.sv | 134 +++++++++++++
 tb/tb_aes_round_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
`default_nettype none
// =============================================================================
// aes_round_sequencer : iterative AES-128 controller driving one round datapath
// Revision: 1.0 - initial release
// =============================================================================
module aes_round_sequencer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_pt,
  input  logic [0:127] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_ct,
  output logic         busy,
  output logic [0:127] dp_state_o,
  output logic [0:127] dp_key_o,
  output logic [3:0]   dp_round_o,
  output logic [7:0]   dp_rcon_o,
  output logic         dp_final_o,
  input  logic [0:127] dp_key_i,
  input  logic [0:127] dp_state_i
);

  localparam logic [3:0] C_LAST_ROUND = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t       r_fsm;
  state_t       w_fsm_nxt;
  logic [0:127] r_state;
  logic [0:127] r_key;
  logic [3:0]   r_rnd;
  logic         w_accept;
  logic         w_last;
  logic         w_release;
  logic [7:0]   w_rcon;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Handshake outputs depend on the registered state only, never on in_valid/out_ready.
  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_accept   = 1'b0;
    w_last     = 1'b0;
    w_release  = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    dp_final_o = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept  = 1'b1;
          w_fsm_nxt = S_ROUND;
        end
      end
      S_ROUND: begin
        busy = 1'b1;
        if (r_rnd == C_LAST_ROUND) begin
          dp_final_o = 1'b1;
          w_last     = 1'b1;
          w_fsm_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_release = 1'b1;
          w_fsm_nxt = S_IDLE;
        end
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_key   <= '0;
      r_rnd   <= '0;
    end else if (w_accept) begin
      r_state <= in_pt ^ in_key;
      r_key   <= in_key;
      r_rnd   <= 4'd1;
    end else if (r_fsm == S_ROUND) begin
      r_state <= dp_state_i;
      r_key   <= dp_key_i;
      if (!w_last) begin
        r_rnd <= r_rnd + 4'd1;
      end
    end else if (w_release) begin
      r_rnd <= '0;
    end
  end

  always_comb begin
    w_rcon = 8'h00;
    case (r_rnd)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  assign dp_state_o = r_state;
  assign dp_key_o   = r_key;
  assign out_ct     = r_state;
  assign dp_round_o = (r_fsm == S_ROUND) ? r_rnd  : 4'd0;
  assign dp_rcon_o  = (r_fsm == S_ROUND) ? w_rcon : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`default_nettype none
// Table-driven bench for aes_round_sequencer with an AES-128 reference round
// datapath (or a pass-through stub) closing the dp_* loop.
module tb_aes_round_sequencer;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_pt;
  logic [0:127] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_ct;
  logic         busy;
  logic [0:127] dp_state_o;
  logic [0:127] dp_key_o;
  logic [3:0]   dp_round_o;
  logic [7:0]   dp_rcon_o;
  logic         dp_final_o;
  logic [0:127] dp_key_i;
  logic [0:127] dp_state_i;
  logic         dp_aes;

  int n_chk;
  int n_err;

  aes_round_sequencer u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pt      (in_pt),
    .in_key     (in_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ct     (out_ct),
    .busy       (busy),
    .dp_state_o (dp_state_o),
    .dp_key_o   (dp_key_o),
    .dp_round_o (dp_round_o),
    .dp_rcon_o  (dp_rcon_o),
    .dp_final_o (dp_final_o),
    .dp_key_i   (dp_key_i),
    .dp_state_i (dp_state_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference AES-128 round datapath ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] s;
    logic [7:0] r;
    s = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gm(s, s);
      r = gm(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [0:127] kexp(input logic [0:127] k, input logic [7:0] rc);
    logic [0:31] w0, w1, w2, w3, t;
    w0 = k[0:31];
    w1 = k[32:63];
    w2 = k[64:95];
    w3 = k[96:127];
    t  = {sb(w3[8:15]) ^ rc, sb(w3[16:23]), sb(w3[24:31]), sb(w3[0:7])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [0:127] rnd(input logic [0:127] s, input logic [0:127] k,
                                       input logic fin);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [0:127] o;
    for (int i = 0; i < 16; i++) a[i] = sb(s[8*i +: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[c*4+r] = a[((c + r) % 4)*4 + r];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
        b[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        b[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        b[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        b[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = b[i] ^ k[8*i +: 8];
    return o;
  endfunction

  assign dp_key_i   = dp_aes ? kexp(dp_key_o, dp_rcon_o) : dp_key_o;
  assign dp_state_i = dp_aes ? rnd(dp_state_o, dp_key_i, dp_final_o) : dp_state_o;

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " in_ready"},   in_ready,   1);
    chk({nm, " out_valid"},  out_valid,  0);
    chk({nm, " busy"},       busy,       0);
    chk({nm, " out_ct"},     out_ct,     0);
    chk({nm, " dp_round"},   dp_round_o, 0);
    chk({nm, " dp_rcon"},    dp_rcon_o,  0);
    chk({nm, " dp_final"},   dp_final_o, 0);
    chk({nm, " dp_state_o"}, dp_state_o, 0);
    chk({nm, " dp_key_o"},   dp_key_o,   0);
  endtask

  logic [7:0] c_rcon [10];

  // Offers one block from IDLE and checks each round cycle up to out_valid.
  task automatic run_block(input logic [0:127] pt, input logic [0:127] key,
                           input logic [0:127] exp, input string nm, input bit stray);
    in_pt    = pt;
    in_key   = key;
    in_valid = 1'b1;
    chk({nm, " in_ready before accept"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (stray) begin
        in_valid  = (k < 10);
        out_ready = (k < 10);
        in_pt     = {$urandom, $urandom, $urandom, $urandom};
        in_key    = {$urandom, $urandom, $urandom, $urandom};
      end
      chk($sformatf("%s r%0d round", nm, k), dp_round_o, k);
      chk($sformatf("%s r%0d rcon", nm, k), dp_rcon_o, c_rcon[k-1]);
      chk($sformatf("%s r%0d final", nm, k), dp_final_o, (k == 10));
      chk($sformatf("%s r%0d out_valid", nm, k), out_valid, 0);
      chk($sformatf("%s r%0d busy/in_ready", nm, k), {busy, in_ready}, 2'b10);
      step();
    end
    chk({nm, " out_valid at latency 10"}, out_valid, 1);
    chk({nm, " out_ct"}, out_ct, exp);
    chk({nm, " done round/rcon/final"}, {dp_round_o, dp_rcon_o, dp_final_o}, 0);
    chk({nm, " done busy/in_ready"}, {busy, in_ready}, 2'b10);
  endtask

  task automatic release_out(input string nm);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({nm, " released out_valid"}, out_valid, 0);
    chk({nm, " released in_ready"}, in_ready, 1);
    chk({nm, " released busy"}, busy, 0);
  endtask

  typedef struct {
    logic [0:127] pt;
    logic [0:127] key;
    logic [0:127] ct;
    logic         aes;
    string        name;
  } vec_t;

  localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  vec_t         tbl [4];
  logic [0:127] bb_pt  [4];
  logic [0:127] bb_key [4];
  logic [0:127] bb_ct  [4];
  int           acc_cyc [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, m;
    bit  acc;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pt = '0; in_key = '0; dp_aes = 1'b0;
    c_rcon = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    tbl[0] = '{C1_PT, C1_KEY, C1_CT, 1'b1, "fips_c1"};
    tbl[1] = '{B_PT, B_KEY, B_CT, 1'b1, "fips_b"};
    tbl[2] = '{128'h0, C1_KEY, C1_KEY, 1'b0, "pass_zero_pt"};
    tbl[3] = '{128'hffffffff00000000a5a5a5a55a5a5a5a, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f,
               128'hf0f0f0f00f0f0f0faaaaaaaa55555555, 1'b0, "pass_xor"};

    repeat (2) step();
    chk_reset("in reset");
    rst_n = 1'b1;
    step();
    chk_reset("idle after reset");

    for (int i = 0; i < 4; i++) begin
      dp_aes = tbl[i].aes;
      run_block(tbl[i].pt, tbl[i].key, tbl[i].ct, tbl[i].name, 1'b0);
      release_out(tbl[i].name);
    end

    // Backpressure: result held, in_valid pulses must not be sampled in DONE.
    dp_aes = 1'b1;
    run_block(B_PT, B_KEY, B_CT, "bp", 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("bp hold%0d valid/ready", i), {out_valid, in_ready}, 2'b10);
      chk($sformatf("bp hold%0d out_ct", i), out_ct, B_CT);
      in_valid = i[0];
      in_pt    = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    in_valid = 1'b0;
    release_out("bp");
    chk("bp out_ct after release", out_ct, B_CT);
    step();
    chk("bp still idle", {in_ready, busy}, 2'b10);

    // Stray out_ready in IDLE, then stray in_valid/out_ready during ROUND.
    out_ready = 1'b1;
    repeat (2) step();
    chk("stray idle state", {in_ready, busy, out_valid}, 3'b100);
    out_ready = 1'b0;
    run_block(C1_PT, C1_KEY, C1_CT, "stray", 1'b1);
    release_out("stray");

    // Back-to-back with in_valid and out_ready held high.
    bb_pt  = '{C1_PT, B_PT, C1_PT, B_PT};
    bb_key = '{C1_KEY, B_KEY, C1_KEY, B_KEY};
    bb_ct  = '{C1_CT, B_CT, C1_CT, B_CT};
    n = 0; m = 0;
    in_pt = bb_pt[0]; in_key = bb_key[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && m < 4; cyc++) begin
      if (out_valid) begin
        chk($sformatf("b2b out_ct %0d", m), out_ct, bb_ct[m]);
        m++;
      end
      acc = in_ready && in_valid;
      if (acc) begin
        acc_cyc[n] = cyc;
        n++;
      end
      step();
      if (acc) begin
        if (n < 4) begin
          in_pt  = bb_pt[n];
          in_key = bb_key[n];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    chk("b2b outputs seen", m, 4);
    chk("b2b accepts seen", n, 4);
    for (int i = 1; i < 4 && i < n; i++)
      chk($sformatf("b2b accept spacing %0d", i), acc_cyc[i] - acc_cyc[i-1], 12);
    chk("b2b idle at end", {in_ready, busy}, 2'b10);

    // Asynchronous reset in round 5, then a clean block.
    in_pt = C1_PT; in_key = C1_KEY; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("midop round before reset", dp_round_o, 5);
    #2 rst_n = 1'b0;
    #1 chk_reset("async reset midop");
    step();
    rst_n = 1'b1;
    step();
    chk_reset("after midop reset");
    run_block(C1_PT, C1_KEY, C1_CT, "post_reset", 1'b0);
    release_out("post_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
